// File: rtl/core_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// core_store_unit_pkg
//   Shared definitions for the store unit: bus widths, STORE funct3 codes,
//   FSM state encoding and small helpers used by the alignment logic.
// ----------------------------------------------------------------------------
package core_store_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = DATA_WIDTH / 8;

  // STORE funct3 codes; everything from 3 to 7 is illegal.
  localparam logic [2:0] STORE_SB = 3'd0;
  localparam logic [2:0] STORE_SH = 3'd1;
  localparam logic [2:0] STORE_SW = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ_LO,
    ST_REQ_HI,
    ST_DONE
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == STORE_SB) || (op == STORE_SH) || (op == STORE_SW);
  endfunction

  // Byte-enable mask of the access before it is shifted into its lanes.
  function automatic logic [BE_WIDTH-1:0] op_mask(input logic [2:0] op);
    logic [BE_WIDTH-1:0] m;
    case (op)
      STORE_SB: m = 4'b0001;
      STORE_SH: m = 4'b0011;
      STORE_SW: m = 4'b1111;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  // Expands a byte-enable mask into a bit mask (one byte of ones per enable).
  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [BE_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] bm;
    for (int i = 0; i < BE_WIDTH; i++) begin
      bm[8*i +: 8] = {8{m[i]}};
    end
    return bm;
  endfunction

endpackage

// File: rtl/core_store_align.sv
// ----------------------------------------------------------------------------
// core_store_align
//   Purely combinational lane alignment for a store. The access is shifted
//   into a 64-bit window spanning the addressed word and the next one; the
//   upper half is only non-zero when the access crosses a word boundary.
// Ports
//   op      in  3   STORE funct3
//   off     in  2   byte offset within the word (addr[1:0])
//   data    in  32  rs2 value, LSB-justified
//   be8     out 8   byte enables over the two-word window
//   d64     out 64  lane-aligned data over the two-word window
//   split   out 1   access touches the second word
//   illegal out 1   funct3 is not a supported store
// ----------------------------------------------------------------------------
module core_store_align
  import core_store_unit_pkg::*;
(
  input  logic [2:0]              op,
  input  logic [1:0]              off,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [2*BE_WIDTH-1:0]   be8,
  output logic [2*DATA_WIDTH-1:0] d64,
  output logic                    split,
  output logic                    illegal
);

  logic [BE_WIDTH-1:0] mask;

  always_comb begin
    mask    = op_mask(op);
    be8     = {{BE_WIDTH{1'b0}}, mask} << off;
    // Unused upper bytes of rs2 are cleared so disabled lanes carry zero.
    d64     = {{DATA_WIDTH{1'b0}}, data & byte_mask(mask)} << {off, 3'b000};
    split   = |be8[2*BE_WIDTH-1:BE_WIDTH];
    illegal = !op_is_legal(op);
  end

endmodule

// File: rtl/core_store_unit.sv
// ----------------------------------------------------------------------------
// core_store_unit
//   Store path between the MEM stage and the data-memory write port. Accepts
//   one store at a time, aligns it onto the bus, and issues one or two word
//   writes (two when the access straddles a word boundary). The MEM stage is
//   held off via m_store_ready_o until the final grant has been seen.
// Ports
//   clk_i             in  1   core clock
//   rst_i             in  1   asynchronous, active-high reset
//   m_store_valid_i   in  1   MEM stage presents a store
//   m_store_op_i      in  3   STORE funct3
//   m_addr_i          in  32  byte address
//   m_wdata_i         in  32  rs2 value, LSB-justified
//   m_store_ready_o   out 1   idle and accepting (accept = valid & ready)
//   m_store_done_o    out 1   one-cycle completion pulse
//   m_store_illegal_o out 1   one-cycle pulse with done for illegal funct3
//   data_req_o        out 1   write request
//   data_we_o         out 1   write enable, mirrors data_req_o
//   data_addr_o       out 32  word-aligned address
//   data_be_o         out 4   byte enables
//   data_wdata_o      out 32  lane-aligned write data
//   data_gnt_i        in  1   memory accepts the request this cycle
// ----------------------------------------------------------------------------
module core_store_unit
  import core_store_unit_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m_store_valid_i,
  input  logic [2:0]            m_store_op_i,
  input  logic [DATA_WIDTH-1:0] m_addr_i,
  input  logic [DATA_WIDTH-1:0] m_wdata_i,
  output logic                  m_store_ready_o,
  output logic                  m_store_done_o,
  output logic                  m_store_illegal_o,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [DATA_WIDTH-1:0] data_addr_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_gnt_i
);

  state_e                  state_q, state_d;
  logic [2:0]              op_q;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic [2*BE_WIDTH-1:0]   be8;
  logic [2*DATA_WIDTH-1:0] d64;
  logic                    split;
  logic                    illegal;

  logic                    accept;
  logic [DATA_WIDTH-1:0]   word_base;

  assign accept    = m_store_valid_i && (state_q == ST_IDLE);
  assign word_base = {addr_q[DATA_WIDTH-1:2], 2'b00};

  // Alignment works on the captured store so bus fields stay stable while
  // the MEM stage changes its inputs during a stall.
  core_store_align u_align (
    .op      (op_q),
    .off     (addr_q[1:0]),
    .data    (data_q),
    .be8     (be8),
    .d64     (d64),
    .split   (split),
    .illegal (illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= m_store_op_i;
        addr_q <= m_addr_i;
        data_q <= m_wdata_i;
      end
    end
  end

  // Bus outputs decode from the state register only, so an asynchronous
  // reset drops data_req_o immediately and the grant cannot glitch them.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d           = state_q;
    m_store_ready_o   = 1'b0;
    m_store_done_o    = 1'b0;
    m_store_illegal_o = 1'b0;
    data_req_o        = 1'b0;
    data_we_o         = 1'b0;
    data_addr_o       = '0;
    data_be_o         = '0;
    data_wdata_o      = '0;

    case (state_q)
      ST_IDLE: begin
        m_store_ready_o = 1'b1;
        if (m_store_valid_i) begin
          state_d = op_is_legal(m_store_op_i) ? ST_REQ_LO : ST_DONE;
        end
      end

      ST_REQ_LO: begin
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        data_addr_o  = word_base;
        data_be_o    = be8[BE_WIDTH-1:0];
        data_wdata_o = d64[DATA_WIDTH-1:0];
        if (data_gnt_i) begin
          state_d = split ? ST_REQ_HI : ST_DONE;
        end
      end

      ST_REQ_HI: begin
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        // Plain 32-bit add: the last word of the address space wraps to 0.
        data_addr_o  = word_base + DATA_WIDTH'(4);
        data_be_o    = be8[2*BE_WIDTH-1:BE_WIDTH];
        data_wdata_o = d64[2*DATA_WIDTH-1:DATA_WIDTH];
        if (data_gnt_i) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        m_store_done_o    = 1'b1;
        m_store_illegal_o = illegal;
        state_d           = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_store_unit.sv
// ----------------------------------------------------------------------------
// tb_core_store_unit
//   Directed bench for core_store_unit. Expected bus writes are queued before
//   each store is issued and compared in order as the unit requests them.
// ----------------------------------------------------------------------------
module tb_core_store_unit;
  import core_store_unit_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m_store_valid_i;
  logic [2:0]  m_store_op_i;
  logic [31:0] m_addr_i;
  logic [31:0] m_wdata_i;
  logic        m_store_ready_o;
  logic        m_store_done_o;
  logic        m_store_illegal_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;

  int   errors = 0;
  int   checks = 0;
  txn_t exp_q[$];

  core_store_unit dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .m_store_valid_i   (m_store_valid_i),
    .m_store_op_i      (m_store_op_i),
    .m_addr_i          (m_addr_i),
    .m_wdata_i         (m_wdata_i),
    .m_store_ready_o   (m_store_ready_o),
    .m_store_done_o    (m_store_done_o),
    .m_store_illegal_o (m_store_illegal_o),
    .data_req_o        (data_req_o),
    .data_we_o         (data_we_o),
    .data_addr_o       (data_addr_o),
    .data_be_o         (data_be_o),
    .data_wdata_o      (data_wdata_o),
    .data_gnt_i        (data_gnt_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    txn_t t;
    t.addr  = addr;
    t.be    = be;
    t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  // Issues one store at the current negedge and follows it to completion.
  // Cycle c counts negedges after the accepting posedge; done is expected at
  // c == exp_done. lo_waits/hi_waits hold grant low on each request.
  // abort_hi pulses reset while the second (high) request is pending.
  task automatic run_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input int lo_waits, input int hi_waits,
                           input int exp_done, input logic exp_ill, input bit abort_hi);
    int   c = 0;
    int   pops = 0;
    int   wl = lo_waits;
    bit   done_seen = 1'b0;
    txn_t t;

    check({tag, "/ready_at_issue"}, m_store_ready_o, 1);
    m_store_valid_i = 1'b1;
    m_store_op_i    = op;
    m_addr_i        = addr;
    m_wdata_i       = data;
    data_gnt_i      = 1'($urandom_range(0, 1));
    @(posedge clk_i);
    #1;
    // MEM keeps valid high while stalled; changed fields must be ignored.
    m_store_op_i = STORE_SB;
    m_addr_i     = 32'h0000_0000;
    m_wdata_i    = 32'hFFFF_FFFF;

    while (!done_seen && c < 20) begin
      c++;
      @(negedge clk_i);
      if (m_store_done_o) begin
        done_seen = 1'b1;
        check({tag, "/done_cycle"}, c, exp_done);
        check({tag, "/illegal"}, m_store_illegal_o, exp_ill);
        check({tag, "/ready_in_done"}, m_store_ready_o, 0);
        check({tag, "/req_in_done"}, data_req_o, 0);
        check({tag, "/pending_writes"}, exp_q.size(), 0);
        m_store_valid_i = 1'b0;
      end else begin
        check({tag, "/illegal_early"}, m_store_illegal_o, 0);
        check({tag, "/ready_busy"}, m_store_ready_o, 0);
        if (data_req_o) begin
          if (exp_q.size() == 0) begin
            check({tag, "/unexpected_req"}, data_req_o, 0);
            data_gnt_i = 1'b1;
          end else begin
            t = exp_q[0];
            check({tag, "/addr"}, data_addr_o, t.addr);
            check({tag, "/be"}, data_be_o, t.be);
            check({tag, "/wdata"}, data_wdata_o, t.wdata);
            check({tag, "/we"}, data_we_o, 1);
            if (abort_hi && pops == 1) begin
              data_gnt_i = 1'b0;
              rst_i = 1'b1;
              #1;
              check({tag, "/rst_req"}, data_req_o, 0);
              check({tag, "/rst_ready"}, m_store_ready_o, 1);
              check({tag, "/rst_done"}, m_store_done_o, 0);
              m_store_valid_i = 1'b0;
              #1;
              rst_i = 1'b0;
              exp_q.delete();
              return;
            end
            if (wl == 0) begin
              data_gnt_i = 1'b1;
              void'(exp_q.pop_front());
              pops++;
              wl = hi_waits;
            end else begin
              data_gnt_i = 1'b0;
              wl--;
            end
          end
        end else begin
          // Grant without a request must have no effect.
          data_gnt_i = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!done_seen) begin
      check({tag, "/done_timeout"}, 0, 1);
      exp_q.delete();
    end
    m_store_valid_i = 1'b0;
    data_gnt_i      = 1'b0;
    @(negedge clk_i);
    check({tag, "/ready_after"}, m_store_ready_o, 1);
    check({tag, "/done_after"}, m_store_done_o, 0);
  endtask

  initial begin
    rst_i           = 1'b1;
    m_store_valid_i = 1'b0;
    m_store_op_i    = '0;
    m_addr_i        = '0;
    m_wdata_i       = '0;
    data_gnt_i      = 1'b0;

    repeat (2) @(negedge clk_i);
    check("reset/ready", m_store_ready_o, 1);
    check("reset/done", m_store_done_o, 0);
    check("reset/illegal", m_store_illegal_o, 0);
    check("reset/req", data_req_o, 0);
    check("reset/we", data_we_o, 0);
    check("reset/addr", data_addr_o, 0);
    check("reset/be", data_be_o, 0);
    check("reset/wdata", data_wdata_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 1: aligned word, done two cycles after accept.
    push_exp(32'h0000_0100, 4'hF, 32'hDEAD_BEEF);
    run_store("sw_aligned", STORE_SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 2, 1'b0, 1'b0);

    // 2: byte into top lane, upper rs2 bytes discarded.
    push_exp(32'h0000_0200, 4'b1000, 32'hAB00_0000);
    run_store("sb_lane3", STORE_SB, 32'h0000_0203, 32'h1234_56AB, 0, 0, 2, 1'b0, 1'b0);

    // 3: misaligned word split across two words.
    push_exp(32'h0000_0100, 4'b1100, 32'h3344_0000);
    push_exp(32'h0000_0104, 4'b0011, 32'h0000_1122);
    run_store("sw_split", STORE_SW, 32'h0000_0102, 32'h1122_3344, 0, 0, 3, 1'b0, 1'b0);

    // 4: halfword at the top of memory, grant held low 3 cycles, wraps to 0.
    push_exp(32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
    push_exp(32'h0000_0000, 4'b0001, 32'h0000_00BE);
    run_store("sh_wrap_wait", STORE_SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 3, 0, 6, 1'b0, 1'b0);

    // 5: illegal funct3, no bus access.
    run_store("illegal_op5", 3'b101, 32'h0000_0300, 32'hCAFE_F00D, 0, 0, 1, 1'b1, 1'b0);

    // Extra lane/mask patterns.
    push_exp(32'h0000_0300, 4'b1100, 32'h5A5A_0000);
    run_store("sh_upper", STORE_SH, 32'h0000_0302, 32'hFFFF_5A5A, 0, 0, 2, 1'b0, 1'b0);
    push_exp(32'h0000_0000, 4'b0010, 32'h0000_7700);
    run_store("sb_lane1", STORE_SB, 32'h0000_0001, 32'hFFFF_FF77, 0, 0, 2, 1'b0, 1'b0);
    push_exp(32'h0000_0400, 4'b0110, 32'h0012_3400);
    run_store("sh_mid", STORE_SH, 32'h0000_0401, 32'hAAAA_1234, 0, 0, 2, 1'b0, 1'b0);
    push_exp(32'h0000_0400, 4'b1000, 32'hD400_0000);
    push_exp(32'h0000_0404, 4'b0111, 32'h00A1_B2C3);
    run_store("sw_off3_hiwait", STORE_SW, 32'h0000_0403, 32'hA1B2_C3D4, 0, 2, 5, 1'b0, 1'b0);
    run_store("illegal_op7", 3'b111, 32'h0000_0000, 32'h0000_0000, 0, 0, 1, 1'b1, 1'b0);

    // 6: reset while the high half is pending, then a normal store.
    push_exp(32'h0000_0500, 4'b1100, 32'h3344_0000);
    push_exp(32'h0000_0504, 4'b0011, 32'h0000_1122);
    run_store("rst_in_hi", STORE_SW, 32'h0000_0502, 32'h1122_3344, 0, 5, 99, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_rst/done", m_store_done_o, 0);
      check("post_rst/req", data_req_o, 0);
      check("post_rst/ready", m_store_ready_o, 1);
    end
    push_exp(32'h0000_0600, 4'hF, 32'h0BAD_F00D);
    run_store("sw_after_rst", STORE_SW, 32'h0000_0600, 32'h0BAD_F00D, 1, 0, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
